// File: rtl/psg_write_arbiter_if.sv
// Requester and PSG-chip signal bundle for the two-requester write arbiter.
// The master modport is the arbiter side; the slave modport is the requesters plus chip.
interface psg_write_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_lock;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_lock;
    logic       req1_ready;
    logic       nWE;
    logic       nCE;
    logic [7:0] D;
    logic       READY;
    logic       busy;
    logic       grant;
    logic       err;

    modport master (
        input  req0_valid, req0_data, req0_lock,
        input  req1_valid, req1_data, req1_lock,
        input  READY,
        output req0_ready, req1_ready,
        output nWE, nCE, D, busy, grant, err
    );

    modport slave (
        output req0_valid, req0_data, req0_lock,
        output req1_valid, req1_data, req1_lock,
        output READY,
        input  req0_ready, req1_ready,
        input  nWE, nCE, D, busy, grant, err
    );
endinterface

// File: rtl/psg_write_arbiter.sv
// Arbitrates two byte requesters onto a PSG chip bus, sequencing nCE/nWE against
// the chip READY line with timeout protection and optional latch/data bus locking.
module psg_write_arbiter #(
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned READY_TIMEOUT  = 64
) (
    input logic                 CLK,
    input logic                 nRST,
    psg_write_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RECOVER = 3'd4
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(READY_TIMEOUT - 32'd1);
    localparam logic [7:0] RC_LAST = (RECOVER_CYCLES == 32'd0) ? 8'd0 : 8'(RECOVER_CYCLES - 32'd1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       nwe_q, nwe_d;
    logic       nce_q, nce_d;
    logic [7:0] d_q, d_d;
    logic       busy_q, busy_d;
    logic       grant_q, grant_d;
    logic       err_q, err_d;
    logic       lock_vld_q, lock_vld_d;
    logic       lock_own_q, lock_own_d;
    logic       prio_q, prio_d;
    logic       elig0_s, elig1_s, pick_s, accept_s;

    assign elig0_s = bus.req0_valid && (!lock_vld_q || (lock_own_q == 1'b0));
    assign elig1_s = bus.req1_valid && (!lock_vld_q || (lock_own_q == 1'b1));
    assign pick_s  = (elig0_s && elig1_s) ? prio_q : elig1_s;

    // Ready is the live acceptance handshake, so it is masked while reset is applied.
    assign bus.req0_ready = nRST && accept_s && !pick_s;
    assign bus.req1_ready = nRST && accept_s && pick_s;
    assign bus.nWE        = nwe_q;
    assign bus.nCE        = nce_q;
    assign bus.D          = d_q;
    assign bus.busy       = busy_q;
    assign bus.grant      = grant_q;
    assign bus.err        = err_q;

    // Next-state, arbitration and chip-strobe decode.
    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        grant_d    = grant_q;
        err_d      = err_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        prio_d     = prio_q;
        accept_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (elig0_s || elig1_s) begin
                    accept_s   = 1'b1;
                    state_d    = S_SETUP;
                    d_d        = pick_s ? bus.req1_data : bus.req0_data;
                    grant_d    = pick_s;
                    prio_d     = ~pick_s;
                    lock_vld_d = pick_s ? bus.req1_lock : bus.req0_lock;
                    lock_own_d = pick_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (!bus.READY) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_RELEASE;
                    err_d      = 1'b1;
                    lock_vld_d = 1'b0;
                end else begin
                    state_d = S_STROBE;
                end
            end
            S_RELEASE: begin
                if (bus.READY) begin
                    state_d = S_RECOVER;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_RECOVER;
                    err_d      = 1'b1;
                    lock_vld_d = 1'b0;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_RECOVER: begin
                if (cnt_q >= RC_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RECOVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cnt_d  = (state_d != state_q) ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        nwe_d  = (state_d != S_STROBE);
        nce_d  = !((state_d == S_SETUP) || (state_d == S_STROBE));
        busy_d = (state_d != S_IDLE);
    end

    // State and registered chip outputs.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            nwe_q      <= 1'b1;
            nce_q      <= 1'b1;
            d_q        <= 8'h00;
            busy_q     <= 1'b0;
            grant_q    <= 1'b0;
            err_q      <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nwe_q      <= nwe_d;
            nce_q      <= nce_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            prio_q     <= prio_d;
        end
    end

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Directed bench for psg_write_arbiter: table of arbitration vectors plus
// hand-written sequences for timing, lock, timeout and reset corners.
module tb_psg_write_arbiter;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        int         eg;
        logic [7:0] ed;
    } vec_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   r0_cnt = 0;
    int   r1_cnt = 0;
    logic chip_stuck = 1'b0;
    logic prev_nwe = 1'b1;
    int   hold = 0;
    vec_t tbl[8];

    psg_write_arbiter_if bus ();

    psg_write_arbiter #(
        .RECOVER_CYCLES(2),
        .READY_TIMEOUT (64)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Chip model: READY drops one cycle after nWE falls, returns two cycles later.
    always @(posedge CLK) begin
        prev_nwe <= bus.nWE;
        if (!nRST) begin
            bus.READY <= 1'b1;
            hold      <= 0;
        end else if (chip_stuck) begin
            bus.READY <= 1'b1;
        end else if (prev_nwe && !bus.nWE) begin
            bus.READY <= 1'b0;
            hold      <= 2;
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) bus.READY <= 1'b1;
        end
    end

    // Ready pulse counters, one count per accepting edge.
    always @(posedge CLK) begin
        if (nRST && bus.req0_ready) r0_cnt <= r0_cnt + 1;
        if (nRST && bus.req1_ready) r1_cnt <= r1_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns which requester was accepted (-1 none, 2 both).
    task automatic drive_and_accept(input logic v0, input logic [7:0] d0, input logic l0,
                                    input logic v1, input logic [7:0] d1, input logic l1,
                                    output int got);
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_lock = l0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_lock = l1;
        got = -1;
        for (int k = 0; k < 40 && got < 0; k++) begin
            if (k != 0) @(negedge CLK);
            #1;
            if (bus.req0_ready && bus.req1_ready) got = 2;
            else if (bus.req0_ready)              got = 0;
            else if (bus.req1_ready)              got = 1;
        end
        if (got < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge CLK);
            // Accepted requester drops valid and scribbles its data bus.
            if (got == 0) begin bus.req0_valid = 1'b0; bus.req0_data = ~d0; end
            if (got == 1) begin bus.req1_valid = 1'b0; bus.req1_data = ~d1; end
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge CLK);
            if (!bus.busy) ok = 1'b1;
        end
        check("reach_idle", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int   got;
        int   snap;
        int   nwe_low;
        bit   ok;
        logic [2:0] traj [8];

        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h21, 1'b0, 1, 8'h21};
        tbl[1] = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h22, 1'b0, 0, 8'h12};
        tbl[2] = '{1'b1, 8'h13, 1'b0, 1'b1, 8'h23, 1'b0, 1, 8'h23};
        tbl[3] = '{1'b1, 8'h14, 1'b0, 1'b1, 8'h24, 1'b0, 0, 8'h14};
        tbl[4] = '{1'b0, 8'h15, 1'b0, 1'b1, 8'h25, 1'b0, 1, 8'h25};
        tbl[5] = '{1'b0, 8'h16, 1'b0, 1'b1, 8'h26, 1'b0, 1, 8'h26};
        tbl[6] = '{1'b1, 8'h17, 1'b0, 1'b0, 8'h27, 1'b0, 0, 8'h17};
        tbl[7] = '{1'b1, 8'h18, 1'b0, 1'b1, 8'h28, 1'b0, 1, 8'h28};
        // {nWE, nCE, busy}: SETUP, STROBE x2, RELEASE x2, RECOVER x2, IDLE
        traj[0] = 3'b101; traj[1] = 3'b001; traj[2] = 3'b001; traj[3] = 3'b111;
        traj[4] = 3'b111; traj[5] = 3'b111; traj[6] = 3'b111; traj[7] = 3'b110;

        // Reset with a valid requester present: no ready pulse, all outputs idle.
        bus.req0_valid = 1'b1; bus.req0_data = 8'h5A; bus.req0_lock = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_lock = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_nWE",   {31'd0, bus.nWE},        32'd1);
        check("rst_nCE",   {31'd0, bus.nCE},        32'd1);
        check("rst_D",     {24'd0, bus.D},          32'h00);
        check("rst_busy",  {31'd0, bus.busy},       32'd0);
        check("rst_grant", {31'd0, bus.grant},      32'd0);
        check("rst_err",   {31'd0, bus.err},        32'd0);
        check("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        bus.req0_valid = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);

        // Single write of 9F with full strobe trajectory.
        drive_and_accept(1'b1, 8'h9F, 1'b0, 1'b0, 8'h00, 1'b0, got);
        check("single_who", got, 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge CLK);
            check($sformatf("single_traj%0d", c), {29'd0, bus.nWE, bus.nCE, bus.busy}, {29'd0, traj[c]});
            check($sformatf("single_D%0d", c), {24'd0, bus.D}, 32'h9F);
        end
        check("single_pulses", r0_cnt + r1_cnt, 32'd1);
        check("single_err", {31'd0, bus.err}, 32'd0);

        // Round-robin / single-requester table.
        foreach (tbl[i]) begin
            snap = r0_cnt + r1_cnt;
            drive_and_accept(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, got);
            wait_idle();
            check($sformatf("vec%0d_who", i),    got, tbl[i].eg);
            check($sformatf("vec%0d_grant", i),  {31'd0, bus.grant}, tbl[i].eg);
            check($sformatf("vec%0d_D", i),      {24'd0, bus.D}, {24'd0, tbl[i].ed});
            check($sformatf("vec%0d_pulses", i), r0_cnt + r1_cnt - snap, 32'd1);
        end

        // Lock pair: req1 waits until req0 releases the lock, even while req0 is idle.
        drive_and_accept(1'b1, 8'h8E, 1'b1, 1'b1, 8'h55, 1'b0, got);
        check("lock_first_who", got, 32'd0);
        wait_idle();
        check("lock_first_D", {24'd0, bus.D}, 32'h8E);
        snap = r1_cnt;
        repeat (10) @(negedge CLK);
        check("lock_hold_r1", r1_cnt - snap, 32'd0);
        check("lock_hold_busy", {31'd0, bus.busy}, 32'd0);
        drive_and_accept(1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0, got);
        check("lock_second_who", got, 32'd0);
        wait_idle();
        check("lock_second_D", {24'd0, bus.D}, 32'h0F);
        drive_and_accept(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, got);
        check("lock_after_who", got, 32'd1);
        wait_idle();
        check("lock_after_D", {24'd0, bus.D}, 32'h55);

        // Timeout: chip never drops READY; lock taken on this byte must be dropped.
        chip_stuck = 1'b1;
        drive_and_accept(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, got);
        check("to_who", got, 32'd0);
        nwe_low = 0;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (!bus.busy) begin
                ok = 1'b1;
            end else begin
                if (!bus.nWE) nwe_low = nwe_low + 1;
                @(negedge CLK);
            end
        end
        check("to_idle", {31'd0, ok}, 32'd1);
        check("to_strobe_len", nwe_low, 32'd64);
        check("to_err", {31'd0, bus.err}, 32'd1);
        check("to_nWE", {31'd0, bus.nWE}, 32'd1);
        check("to_D", {24'd0, bus.D}, 32'h77);
        chip_stuck = 1'b0;
        drive_and_accept(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, got);
        check("to_unlock_who", got, 32'd1);
        wait_idle();
        check("to_unlock_D", {24'd0, bus.D}, 32'h66);
        check("to_err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset while strobing.
        drive_and_accept(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, got);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (!bus.nWE) ok = 1'b1;
            else @(negedge CLK);
        end
        check("rs_in_strobe", {31'd0, ok}, 32'd1);
        nRST = 1'b0;
        bus.req0_valid = 1'b1;
        @(negedge CLK);
        #1;
        check("rs_nWE",   {31'd0, bus.nWE},  32'd1);
        check("rs_nCE",   {31'd0, bus.nCE},  32'd1);
        check("rs_D",     {24'd0, bus.D},    32'h00);
        check("rs_busy",  {31'd0, bus.busy}, 32'd0);
        check("rs_err",   {31'd0, bus.err},  32'd0);
        check("rs_ready", {31'd0, bus.req0_ready}, 32'd0);
        bus.req0_valid = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        check("rs_after_busy", {31'd0, bus.busy}, 32'd0);
        check("rs_after_nWE",  {31'd0, bus.nWE},  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psg_write_arbiter.md
PSG_WRITE_ARBITER -- requirements
Module: psg_write_arbiter

Interface
REQ-001 Parameter RECOVER_CYCLES, default 2, meaning idle CLK cycles enforced between successive chip writes (range 0-15).
REQ-002 Parameter READY_TIMEOUT, default 64, meaning max CLK cycles spent waiting on chip READY in any one state before abort (range 2-255).
REQ-003 CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 holds a byte for the chip.
REQ-006 req0_data  input  8  requester 0 command byte (latch or data byte, chip format).
REQ-007 req0_lock  input  1  requester 0 wants the bus held for its next byte (latch/data pair).
REQ-008 req0_ready  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-009 req1_valid, req1_data[7:0], req1_lock, req1_ready  same directions/widths/meaning for requester 1.
REQ-010 nWE  output  1  chip write enable, active-low.
REQ-011 nCE  output  1  chip enable, active-low.
REQ-012 D  output  8  chip data bus.
REQ-013 READY  input  1  chip ready; low while chip is absorbing a write.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 grant  output  1  index of requester owning the current or last write.
REQ-016 err  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-017 FSM states: IDLE, SETUP, STROBE, RELEASE, RECOVER.
REQ-018 IDLE: nWE=1, nCE=1; when a requester is eligible and valid, latch its byte into D, pulse its reqN_ready for exactly that cycle, set grant, go to SETUP next cycle.
REQ-019 Eligibility: if lock owner set, only owner eligible; otherwise both valid requesters eligible.
REQ-020 Arbitration among two eligible: round-robin, the requester not granted last wins; after reset requester 0 has priority.
REQ-021 Lock: byte accepted with lock=1 sets lock owner to that requester; byte accepted from owner with lock=0 clears lock owner.
REQ-022 SETUP: exactly 1 cycle; nCE=0, nWE=1, D stable; then STROBE.
REQ-023 STROBE: nCE=0, nWE=0; leave to RELEASE on first cycle READY sampled 0, or after READY_TIMEOUT cycles in STROBE.
REQ-024 RELEASE: nCE=1, nWE=1; leave to RECOVER on first cycle READY sampled 1, or after READY_TIMEOUT cycles in RELEASE.
REQ-025 Timeout in STROBE or RELEASE sets err=1, clears lock owner, continues normal transition to next state.
REQ-026 RECOVER: nWE=1, nCE=1 for RECOVER_CYCLES cycles then IDLE; RECOVER_CYCLES=0 means RECOVER lasts 1 cycle.
REQ-027 D holds last written byte in every state after SETUP until next acceptance.
REQ-028 reqN_data/lock sampled only in the acceptance cycle; later changes do not affect the write in progress.
REQ-029 At most one reqN_ready pulse per write; none outside IDLE.
REQ-030 Requester deasserting valid before acceptance: no write, no ready pulse, no state change.
REQ-031 Lock owner deasserting valid while locked: bus stays reserved; other requester not served until owner sends lock=0 byte or timeout.
REQ-032 Timeout counter: 8-bit, cleared on every state entry, saturates.

Reset
REQ-033 While nRST=0 at posedge: state=IDLE, nWE=1, nCE=1, D=8'h00, req0_ready=0, req1_ready=0, busy=0, grant=0, err=0, lock owner cleared, round-robin pointer favours requester 0.
REQ-034 Reset mid-write (any state) takes effect next posedge; no partial strobe continues, no ready pulse issued that cycle.

Verification
REQ-035 Single write: req0 byte 8'h9F, chip model drops READY 1 cycle after nWE low, restores 2 cycles later -> req0_ready pulse, D=9F, sequence IDLE-SETUP-STROBE-RELEASE-RECOVER(2)-IDLE, nWE low until READY low seen.
REQ-036 Contention: both valid continuously, lock=0 -> accepted bytes alternate 0,1,0,1; grant toggles each write.
REQ-037 Lock pair: req0 sends 8'h8E lock=1 then 8'h0F lock=0, req1 valid throughout -> req1 accepted only after 8'h0F write completes.
REQ-038 Timeout: chip model holds READY=1 forever -> after 64 STROBE cycles err=1, nWE returns high, FSM reaches IDLE, lock cleared.
REQ-039 Reset in STROBE: assert nRST=0 one cycle -> next cycle nWE=1, nCE=1, D=00, busy=0, err=0.
REQ-040 Data change after accept: req1 changes req1_data the cycle after ready pulse -> D unchanged through write.
